driver: RTL and testbench
=========================

Name: driver

Overview:
- Debounce-and-pulse block. Watches a 7-bit `state` bus for changes, waits until the bus has been stable for a settle interval, then raises `enable` for a fixed hold interval.
- Sits between the master-controller state logic and downstream drivers/relays. Downstream logic acts only on settled state values.

Parameters:
- STATE_W, 7, width of the monitored state bus.
- SETTLE_BITS, 3, settle counter width; settle interval = 2^SETTLE_BITS-1 = 7 clock cycles.
- HOLD_BITS, 5, hold counter width; enable high time = 2^HOLD_BITS-1 = 31 clock cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- state  input  STATE_W  monitored state bus; asynchronous to nothing, sampled on clk.
- enable  output  1  registered; high = settled state valid, drive outputs.

Behaviour:
- Registers: last_state (STATE_W), settle_cnt (SETTLE_BITS), hold_cnt (HOLD_BITS), fsm {IDLE, SETTLE, HOLD}, pending (1), enable.
- Reset, at a clk edge with rst_n=0:
  - enable=0, fsm=IDLE, counters=0, pending=0.
  - last_state loads the current `state`, so leaving reset never causes a spurious pulse.
- Change detect: chg = (state != last_state) at a rising edge. last_state <= state on every non-reset edge.
- IDLE:
  - chg -> SETTLE, settle_cnt=0.
  - Otherwise stay; enable=0.
- SETTLE:
  - chg -> settle_cnt=0, stay in SETTLE (restart wait).
  - No chg -> settle_cnt++.
  - The 7th consecutive no-change edge (settle_cnt == 2^SETTLE_BITS-2 before increment) -> HOLD, enable<=1, hold_cnt=0.
  - Latency: change seen at edge C, state stable through edges C+1..C+7 -> enable high after edge C+7.
- HOLD:
  - enable stays 1 regardless of state activity; hold_cnt++ each edge.
  - chg during HOLD sets pending=1; enable is not affected.
  - After 31 edges high (enable set at edge E, cleared at edge E+31), enable<=0.
  - At that point: if pending or chg on that edge -> SETTLE with settle_cnt=0, pending=0; else -> IDLE.
- Changes arriving faster than the settle interval hold off enable indefinitely; there is no timeout.
- Reset mid-SETTLE or mid-HOLD aborts immediately: enable=0 on the next edge.
- Counters never wrap. Transitions occur at the terminal counts above.

Decomposition:
- Shared package `driver_pkg`: fsm state typedef {IDLE, SETTLE, HOLD}; default SETTLE_BITS/HOLD_BITS constants.
- One optional sub-module `sat_counter` (clear/increment/terminal-count flag), instantiated twice for settle and hold.
- Otherwise flat.

Test Plan:
- Reset then idle, state=0 constant for 50 cycles -> enable stays 0.
- state 0->1 at one edge, then held -> enable rises 7 edges after the change edge, stays high exactly 31 cycles, returns to 0; single pulse only.
- state incremented every 1.5 cycles, 10 times, then held -> no enable during activity; enable rises 7 edges after the last change.
- state changed every 6.5 cycles, 10 times (each gap < 7 cycles) -> enable stays 0 throughout; rises 7 edges after the final change.
- Pulse in progress, state changed 3 times at 8-cycle spacing inside the 31-cycle window -> enable held continuously for 31 cycles; afterwards a new settle begins and a second 31-cycle pulse follows 7 stable edges later.
- rst_n low for one edge during HOLD -> enable 0 next edge; after release with state unchanged, no pulse.

Source files
------------

// File: rtl/driver_pkg.sv
// rtl/driver_pkg.sv - shared types and default widths for the state debounce/pulse driver
package driver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } fsm_t;

    localparam int DEF_STATE_W     = 7;
    localparam int DEF_SETTLE_BITS = 3;
    localparam int DEF_HOLD_BITS   = 5;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear and terminal-count flag
module sat_counter #(
    parameter int W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic term
);

    logic [W-1:0] count;

    // Terminal flags the last increment before the all-ones value, so the
    // owner can act on the edge that completes 2^W-1 counted edges.
    assign term = (count == {{(W-1){1'b1}}, 1'b0});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/driver.sv
// rtl/driver.sv - waits for the state bus to settle, then pulses enable for a fixed hold time
module driver
    import driver_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int SETTLE_BITS = DEF_SETTLE_BITS,
    parameter int HOLD_BITS   = DEF_HOLD_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] state,
    output logic               enable
);

    fsm_t               fsm;
    fsm_t               fsm_next;
    logic [STATE_W-1:0] last_state;
    logic               pending;
    logic               pending_next;
    logic               enable_next;
    logic               chg;
    logic               settle_clr;
    logic               settle_inc;
    logic               settle_term;
    logic               hold_clr;
    logic               hold_inc;
    logic               hold_term;

    assign chg = (state != last_state);

    sat_counter #(.W(SETTLE_BITS)) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (settle_clr),
        .inc   (settle_inc),
        .term  (settle_term)
    );

    sat_counter #(.W(HOLD_BITS)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (hold_clr),
        .inc   (hold_inc),
        .term  (hold_term)
    );

    // last_state tracks the bus even in reset so release never looks like a change.
    always_ff @(posedge clk) begin
        last_state <= state;
        if (!rst_n) begin
            fsm     <= IDLE;
            pending <= 1'b0;
            enable  <= 1'b0;
        end else begin
            fsm     <= fsm_next;
            pending <= pending_next;
            enable  <= enable_next;
        end
    end

    always_comb begin
        fsm_next     = fsm;
        pending_next = pending;
        enable_next  = enable;
        settle_clr   = 1'b0;
        settle_inc   = 1'b0;
        hold_clr     = 1'b0;
        hold_inc     = 1'b0;
        case (fsm)
            IDLE: begin
                enable_next = 1'b0;
                if (chg) begin
                    fsm_next   = SETTLE;
                    settle_clr = 1'b1;
                end
            end
            SETTLE: begin
                enable_next = 1'b0;
                if (chg) begin
                    settle_clr = 1'b1;
                end else if (settle_term) begin
                    fsm_next    = HOLD;
                    enable_next = 1'b1;
                    hold_clr    = 1'b1;
                end else begin
                    settle_inc = 1'b1;
                end
            end
            HOLD: begin
                enable_next = 1'b1;
                if (chg) begin
                    pending_next = 1'b1;
                end
                // Changes seen during the pulse are deferred, not dropped.
                if (hold_term) begin
                    enable_next  = 1'b0;
                    pending_next = 1'b0;
                    if (pending || chg) begin
                        fsm_next   = SETTLE;
                        settle_clr = 1'b1;
                    end else begin
                        fsm_next = IDLE;
                    end
                end else begin
                    hold_inc = 1'b1;
                end
            end
            default: begin
                fsm_next     = IDLE;
                enable_next  = 1'b0;
                pending_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_driver.sv
// tb/tb_driver.sv - randomized directed bench for driver against an edge-index reference model
module tb_driver;

    localparam int SETTLE_EDGES = 7;
    localparam int HOLD_EDGES   = 31;

    logic       clk;
    logic       rst_n;
    logic [6:0] state;
    logic       enable;

    int   pass_cnt;
    int   total_cnt;
    int   phase;
    int   n;
    int   settle_from;
    int   pulse_end;
    bit   pulse_on;
    bit   pend;
    bit   exp_en;
    logic [6:0] last_s;
    string tag;

    driver dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .state  (state),
        .enable (enable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference expressed in absolute edge numbers: a pulse starts 7 edges after
    // the last change and ends 31 edges later; changes during a pulse defer a settle.
    task automatic model_edge();
        bit c;
        if (!rst_n) begin
            exp_en      = 1'b0;
            pulse_on    = 1'b0;
            pend        = 1'b0;
            settle_from = -1;
            last_s      = state;
        end else begin
            c      = (state !== last_s);
            last_s = state;
            if (pulse_on) begin
                if (c) pend = 1'b1;
                if (n == pulse_end) begin
                    pulse_on    = 1'b0;
                    exp_en      = 1'b0;
                    settle_from = pend ? n : -1;
                    pend        = 1'b0;
                end
            end else if (c) begin
                settle_from = n;
            end else if (settle_from >= 0 && n - settle_from == SETTLE_EDGES) begin
                pulse_on    = 1'b1;
                exp_en      = 1'b1;
                pulse_end   = n + HOLD_EDGES;
                settle_from = -1;
            end
        end
        n++;
    endtask

    task automatic check();
        total_cnt++;
        assert (enable === exp_en) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s edge=%0d enable=%b expected=%b", tag, n, enable, exp_en);
    endtask

    // Half-cycle step: inputs change at posedge+1 or negedge+1, checks at posedge+1.
    task automatic half(input bit do_chg);
        logic [6:0] d;
        if (do_chg) begin
            d     = 7'($urandom_range(1, 127));
            state = state ^ d;
        end
        if (phase == 0) begin
            #5;
            phase = 1;
        end else begin
            @(posedge clk);
            model_edge();
            #1;
            check();
            phase = 0;
        end
    endtask

    task automatic idle_halves(input int k);
        for (int i = 0; i < k; i++) half(1'b0);
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        n           = 0;
        settle_from = -1;
        pulse_end   = 0;
        pulse_on    = 1'b0;
        pend        = 1'b0;
        exp_en      = 1'b0;
        last_s      = '0;
        state       = '0;
        rst_n       = 1'b0;
        tag         = "reset";
        @(posedge clk);
        model_edge();
        #1;
        check();
        phase = 0;
        idle_halves(2);
        rst_n = 1'b1;

        tag = "idle_const";
        idle_halves(100);

        tag = "single_change";
        state = 7'd1;
        idle_halves(100);

        tag = "fast_changes";
        for (int i = 0; i < 10; i++) begin
            half(1'b1);
            idle_halves(2);
        end
        idle_halves(100);

        tag = "near_settle_changes";
        for (int i = 0; i < 10; i++) begin
            half(1'b1);
            idle_halves(12);
        end
        idle_halves(100);

        tag = "changes_in_hold";
        half(1'b1);
        idle_halves(19);
        for (int i = 0; i < 3; i++) begin
            half(1'b1);
            idle_halves(15);
        end
        idle_halves(180);

        tag = "reset_in_hold";
        half(1'b1);
        idle_halves(29);
        rst_n = 1'b0;
        idle_halves(2);
        rst_n = 1'b1;
        idle_halves(100);

        tag = "random";
        for (int i = 0; i < 1200; i++) begin
            if ((i % 2) == 0 && $urandom_range(0, 199) == 0) rst_n = 1'b0;
            else if ((i % 2) == 0) rst_n = 1'b1;
            half($urandom_range(0, 11) == 0);
        end
        rst_n = 1'b1;
        idle_halves(100);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
